// File: rtl/seven_seg_pkg.sv
// Shared segment indices and hex font for the seven-segment scan driver.
// Font entries are active-high, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  function automatic logic [6:0] seg_font(input logic [3:0] nibble);
    return FONT[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational glyph encoder: hex nibble + blank + dp -> active-low segment byte.
module seven_seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg_n
);

  logic [6:0] glyph;

  assign glyph                = blank ? 7'h00 : seg_font(nibble);
  assign seg_n[SEG_G:SEG_A]   = ~glyph;
  assign seg_n[SEG_DP]        = ~dp;

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode N-digit seven-segment driver with frame shadowing.
// Optional brightness PWM gate is compiled in with `define SEVEN_SEG_PWM_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1024,
  parameter int GUARD    = 8,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   word,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  enable,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame
);

  localparam int PCW = $clog2(SCAN_DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PCW-1:0]        pc_q, pc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   word_q, word_d;
  logic [DIGITS-1:0]     dp_q, dp_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  pc_wrap;
  logic                  last_digit;
  logic                  reload;
  logic                  pwm_gate;
  logic                  lit;
  logic [3:0]            nib [DIGITS];
  logic [DIGITS-1:0]     blank;
  logic [7:0]            glyph_n;

  assign pc_wrap    = (pc_q == PCW'(SCAN_DIV - 1));
  assign last_digit = (idx_q == IW'(DIGITS - 1));
  assign reload     = pc_wrap && last_digit;

  // A digit is blanked when it and every digit to its left are zero; digit 0 always shows.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi] = word_q[4*gi +: 4];
      if (gi == 0) begin : g_first
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = lz_en && (word_q[4*DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

`ifdef SEVEN_SEG_PWM_EN
  assign pwm_gate = (pc_q[PCW-1 -: BRIGHT_W] <= bright);
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign pwm_gate      = 1'b1;
`endif

  assign lit = enable && (pc_q >= PCW'(GUARD)) && pwm_gate;

  seven_seg_glyph u_glyph (
    .nibble (nib[idx_q]),
    .blank  (blank[idx_q]),
    .dp     (dp_q[idx_q]),
    .seg_n  (glyph_n)
  );

  always_comb begin
    pc_d    = pc_wrap ? '0 : pc_q + 1'b1;
    idx_d   = idx_q;
    if (pc_wrap) begin
      idx_d = last_digit ? '0 : idx_q + 1'b1;
    end
    word_d  = reload ? word : word_q;
    dp_d    = reload ? dp   : dp_q;
    frame_d = reload;
    an_d    = lit ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d   = lit ? glyph_n : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      dp_q    <= '0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      dp_q    <= dp_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan at DIGITS=4, SCAN_DIV=16, GUARD=2, BRIGHT_W=4.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] word;
  logic [3:0]  dp;
  logic        enable;
  logic        lz_en;
  logic [3:0]  bright;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int fcount  = 0;
  int lit_cnt;
  int dark_bad;

  seven_seg_scan #(
    .DIGITS   (4),
    .SCAN_DIV (16),
    .GUARD    (2),
    .BRIGHT_W (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .word   (word),
    .dp     (dp),
    .enable (enable),
    .lz_en  (lz_en),
    .bright (bright),
    .seg_n  (seg_n),
    .an_n   (an_n),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  // Sample index whose outputs reflect scan state (frame f, digit i, pc p) after release.
  function automatic int k(input int f, input int i, input int p);
    return f*64 + i*16 + p + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (frame) fcount++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
    $display("vec %0d %s cyc=%0d obs=%h exp=%h", vectors, tag, cyc, obs, exp);
  endtask

  initial begin
    rst = 1'b1; word = 16'h1234; dp = 4'b0000; enable = 1'b1; lz_en = 1'b0; bright = 4'hF;
    repeat (3) tick();
    check("rst_seg",   32'(seg_n), 32'hFF);
    check("rst_an",    32'(an_n),  32'hF);
    check("rst_frame", 32'(frame), 32'h0);
    rst = 1'b0;
    cyc = 0;

    // Frame 0: guard darkness then zero glyphs from the reset shadow
    run_to(1);          check("f0_guard_an", 32'(an_n), 32'hF);
    check("f0_guard_seg", 32'(seg_n), 32'hFF);
    run_to(k(0,0,2));   check("f0_d0_an",  32'(an_n),  32'hE);
    check("f0_d0_seg", 32'(seg_n), 32'hC0);
    run_to(k(0,1,1));   check("f0_d1_guard", 32'(an_n), 32'hF);
    run_to(k(0,3,2));   check("f0_d3_an",  32'(an_n),  32'h7);
    check("f0_d3_seg", 32'(seg_n), 32'hC0);
    run_to(63);         check("frame_pre", 32'(frame), 32'h0);
    run_to(64);         check("frame_64",  32'(frame), 32'h1);

    // Frame 1 shows 1234; a mid-frame write of ABCD must not tear it
    run_to(k(1,0,2));   check("f1_d0_seg", 32'(seg_n), 32'h99);
    check("f1_d0_an", 32'(an_n), 32'hE);
    run_to(k(1,0,15));  check("f1_d0_pc15_an", 32'(an_n), 32'hE);
    word = 16'hABCD;
    run_to(k(1,3,2));   check("f1_d3_seg", 32'(seg_n), 32'hF9);
    check("f1_d3_an", 32'(an_n), 32'h7);
    run_to(k(2,0,2));   check("f2_d0_seg", 32'(seg_n), 32'hA1);
    check("f2_d0_an", 32'(an_n), 32'hE);
    run_to(k(2,3,2));   check("f2_d3_seg", 32'(seg_n), 32'h88);
    run_to(192);        check("frame_192", 32'(frame), 32'h1);
    check("frame_count3", 32'(fcount), 32'd3);

    // Leading-zero blanking
    word = 16'h0050; lz_en = 1'b1;
    run_to(k(4,0,2));   check("lz_d0_seg", 32'(seg_n), 32'hC0);
    run_to(k(4,1,2));   check("lz_d1_seg", 32'(seg_n), 32'h92);
    check("lz_d1_an", 32'(an_n), 32'hD);
    run_to(k(4,2,2));   check("lz_d2_seg", 32'(seg_n), 32'hFF);
    check("lz_d2_an", 32'(an_n), 32'hB);
    run_to(k(4,3,2));   check("lz_d3_seg", 32'(seg_n), 32'hFF);
    word = 16'h0000; dp = 4'b1000;
    run_to(k(5,0,2));   check("lz0_d0_seg", 32'(seg_n), 32'hC0);
    run_to(k(5,1,2));   check("lz0_d1_seg", 32'(seg_n), 32'hFF);
    run_to(k(5,3,2));   check("lz0_d3_dp_seg", 32'(seg_n), 32'h7F);
    check("lz0_d3_an", 32'(an_n), 32'h7);
    lz_en = 1'b0; dp = 4'b0000;
    run_to(k(6,3,2));   check("nolz_d3_seg", 32'(seg_n), 32'hC0);

    // Frame 7 with enable low: fully dark, scan and frame pulse continue
    run_to(448);
    enable = 1'b0; word = 16'h1234;
    dark_bad = 0;
    while (cyc < 512) begin
      tick();
      if (an_n !== 4'hF || seg_n !== 8'hFF) dark_bad++;
    end
    check("disable_dark", 32'(dark_bad), 32'd0);
    check("disable_frame", 32'(frame), 32'h1);
    check("frame_count8", 32'(fcount), 32'd8);
    enable = 1'b1;

    // Frame 8 shows 1234; reset hits at pc=9 of digit 2
    run_to(k(8,2,2));   check("f8_d2_seg", 32'(seg_n), 32'hA4);
    check("f8_d2_an", 32'(an_n), 32'hB);
    run_to(k(8,2,8));   check("f8_pre_rst_an", 32'(an_n), 32'hB);
    rst = 1'b1;
    tick();
    check("midrst_an",    32'(an_n),  32'hF);
    check("midrst_seg",   32'(seg_n), 32'hFF);
    check("midrst_frame", 32'(frame), 32'h0);
    rst = 1'b0;
    cyc = 0;
    run_to(k(0,0,2));   check("post_rst_an",  32'(an_n),  32'hE);
    check("post_rst_seg", 32'(seg_n), 32'hC0);

    // Brightness gate
    run_to(16);
    bright = 4'h0;
    lit_cnt = 0;
    while (cyc < 32) begin
      tick();
      if (an_n !== 4'hF) lit_cnt++;
    end
`ifdef SEVEN_SEG_PWM_EN
    check("pwm_b0_lit", 32'(lit_cnt), 32'd0);
`else
    check("nopwm_b0_lit", 32'(lit_cnt), 32'd14);
`endif
    bright = 4'h7;
    lit_cnt = 0;
    while (cyc < 48) begin
      tick();
      if (an_n !== 4'hF) lit_cnt++;
    end
`ifdef SEVEN_SEG_PWM_EN
    check("pwm_b7_lit", 32'(lit_cnt), 32'd6);
`else
    check("nopwm_b7_lit", 32'(lit_cnt), 32'd14);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
